sample_fetcher: RTL and testbench

- Read-side initiator for the dual-channel waveform sample memory (sine/triangle ROM pair).
- A phase accumulator sets the waveform frequency and a prescaler sets the sample rate.
- On each sample tick it issues one read (read, channel, address) to the memory, captures the returned sample, and presents it downstream (DAC serialiser) with a valid/ready handshake.

---
 rtl/sample_fetcher_pkg.sv | 19 +
 rtl/sample_fetcher_tick_divider.sv | 35 +++
 rtl/sample_fetcher.sv | 108 ++++++++++
 tb/tb_sample_fetcher.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_fetcher_pkg
// Brief    : FSM encoding and channel constants shared with the memory wrapper.
// Revision : 1.0 - initial release
// ============================================================================
package sample_fetcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2
   } fetch_state_t;

   localparam logic CH_SINE = 1'b1;
   localparam logic CH_TRI  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sample_fetcher_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Brief    : Sample-rate prescaler, one-cycle tick every div+1 enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider #(
   parameter int div_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [div_width-1:0] div,
   output logic                 tick
);

   logic [div_width-1:0] r_count;
   logic                 w_terminal;

   // >= rather than == so a div lowered below the running count recovers at once
   assign w_terminal = (r_count >= div);
   assign tick       = enable && w_terminal;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (!enable || w_terminal) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sample_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : sample_fetcher
// Brief    : Phase-accumulator driven read initiator for the waveform sample ROM.
// Revision : 1.0 - initial release
// ============================================================================
module sample_fetcher
   import sample_fetcher_pkg::*;
#(
   parameter int size      = 12,
   parameter int logsize   = 4,
   parameter int acc_width = 16,
   parameter int div_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 channel_sel,
   input  logic [acc_width-1:0] freq_word,
   input  logic [div_width-1:0] div,
   output logic                 mem_read,
   output logic                 mem_channel,
   output logic [logsize-1:0]   mem_address,
   input  logic [size-1:0]      mem_sample,
   output logic [size-1:0]      out_sample,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun,
   input  logic                 clear_overrun
);

   fetch_state_t         r_state;
   logic [acc_width-1:0] r_phase;
   logic                 w_tick;
   logic [logsize-1:0]   w_addr;

   tick_divider #(
      .div_width (div_width)
   ) u_tick_divider (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .div    (div),
      .tick   (w_tick)
   );

   assign w_addr = r_phase[acc_width-1 -: logsize];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_phase     <= '0;
         mem_read    <= 1'b0;
         mem_channel <= CH_TRI;
         mem_address <= '0;
         out_sample  <= '0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (w_tick) begin
            r_phase <= r_phase + freq_word;
         end
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (clear_overrun) begin
            overrun <= 1'b0;
         end

         // Later assignments below override the defaults above (CAPT reload, overrun set).
         case (r_state)
            IDLE: begin
               if (w_tick) begin
                  if (!out_valid || out_ready) begin
                     r_state     <= REQ;
                     mem_read    <= 1'b1;
                     mem_address <= w_addr;
                     mem_channel <= channel_sel;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
            REQ: begin
               mem_read <= 1'b0;
               r_state  <= CAPT;
               if (w_tick) begin
                  overrun <= 1'b1;
               end
            end
            CAPT: begin
               out_sample <= mem_sample;
               out_valid  <= 1'b1;
               r_state    <= IDLE;
               if (w_tick) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               mem_read <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sample_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_fetcher
// Brief    : Directed self-checking bench for sample_fetcher with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_fetcher;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        channel_sel = 1'b1;
   logic [15:0] freq_word = 16'h1000;
   logic [15:0] div = 16'd3;
   logic        mem_read;
   logic        mem_channel;
   logic [3:0]  mem_address;
   logic [11:0] mem_sample = 12'h000;
   logic [11:0] out_sample;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        overrun;
   logic        clear_overrun = 1'b0;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   sample_fetcher dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .channel_sel   (channel_sel),
      .freq_word     (freq_word),
      .div           (div),
      .mem_read      (mem_read),
      .mem_channel   (mem_channel),
      .mem_address   (mem_address),
      .mem_sample    (mem_sample),
      .out_sample    (out_sample),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] rom(input logic ch, input logic [3:0] a);
      return ch ? {4'hA, a, 4'h5} : {4'h3, 4'h0, a};
   endfunction

   // One-cycle-latency sample memory
   always @(posedge clk) begin
      if (mem_read === 1'b1) mem_sample <= rom(mem_channel, mem_address);
   end

   task automatic wait_read(input string name);
      int n = 0;
      @(negedge clk);
      while (mem_read !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (mem_read !== 1'b1) begin
         vectors++; errors++;
         $display("FAIL %s: no mem_read within 50 cycles", name);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; enable = 1'b0; out_ready = 1'b1; clear_overrun = 1'b0;
      channel_sel = 1'b1; freq_word = 16'h1000; div = 16'd3;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      int reads;
      #1;
      vectors++;
      if ({mem_read, mem_channel, mem_address, out_sample, out_valid, overrun} !== 20'h0) begin
         errors++;
         $display("FAIL reset_init: outputs=%h required 0",
                  {mem_read, mem_channel, mem_address, out_sample, out_valid, overrun});
      end
      do_reset();
      enable = 1'b1;
      wait_read("reset_rd0");
      wait_read("reset_rd1");
      #1 rst = 1'b0;
      #1;
      vectors++;
      if ({mem_read, mem_channel, mem_address, out_sample, out_valid, overrun} !== 20'h0) begin
         errors++;
         $display("FAIL reset_midreq: outputs=%h required 0",
                  {mem_read, mem_channel, mem_address, out_sample, out_valid, overrun});
      end
      @(negedge clk);
      rst = 1'b1; enable = 1'b0;
      reads = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (mem_read === 1'b1) reads++;
      end
      vectors++;
      if (reads != 0) begin
         errors++;
         $display("FAIL reset_disabled: mem_read pulses=%0d required 0", reads);
      end
   endtask

   task automatic test_basic_fetch();
      int last;
      logic [3:0] a;
      do_reset();
      enable = 1'b1;
      last = 0;
      for (int i = 0; i < 17; i++) begin
         a = 4'(i);
         wait_read("basic");
         vectors++;
         if (mem_address !== a) begin
            errors++;
            $display("FAIL basic_addr[%0d]: got %0d required %0d", i, mem_address, a);
         end
         if (i > 0) begin
            vectors++;
            if (cyc - last != 4) begin
               errors++;
               $display("FAIL basic_period[%0d]: got %0d required 4", i, cyc - last);
            end
         end
         last = cyc;
         @(negedge clk);
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || out_sample !== rom(1'b1, a)) begin
            errors++;
            $display("FAIL basic_out[%0d]: valid=%b sample=%h required 1/%h",
                     i, out_valid, out_sample, rom(1'b1, a));
         end
      end
      vectors++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL basic_overrun: got %b required 0", overrun);
      end
   endtask

   task automatic test_channel_switch();
      do_reset();
      enable = 1'b1;
      wait_read("chsw_rd0");
      channel_sel = 1'b0;
      vectors++;
      if (mem_channel !== 1'b1) begin
         errors++;
         $display("FAIL chsw_req: mem_channel=%b required 1", mem_channel);
      end
      @(negedge clk);
      vectors++;
      if (mem_channel !== 1'b1 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL chsw_capt: mem_channel=%b mem_read=%b required 1/0", mem_channel, mem_read);
      end
      @(negedge clk);
      vectors++;
      if (out_sample !== rom(1'b1, 4'd0)) begin
         errors++;
         $display("FAIL chsw_sine: got %h required %h", out_sample, rom(1'b1, 4'd0));
      end
      wait_read("chsw_rd1");
      vectors++;
      if (mem_channel !== 1'b0 || mem_address !== 4'd1) begin
         errors++;
         $display("FAIL chsw_next: ch=%b addr=%0d required 0/1", mem_channel, mem_address);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (out_sample !== rom(1'b0, 4'd1)) begin
         errors++;
         $display("FAIL chsw_tri: got %h required %h", out_sample, rom(1'b0, 4'd1));
      end
   endtask

   task automatic test_backpressure();
      int reads;
      do_reset();
      out_ready = 1'b0;
      enable = 1'b1;
      wait_read("bp_rd0");
      reads = 0;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (mem_read === 1'b1) reads++;
      end
      vectors++;
      if (reads != 0 || out_valid !== 1'b1 || out_sample !== rom(1'b1, 4'd0) || overrun !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold: reads=%0d valid=%b sample=%h overrun=%b required 0/1/%h/1",
                  reads, out_valid, out_sample, overrun, rom(1'b1, 4'd0));
      end
      clear_overrun = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      clear_overrun = 1'b0;
      vectors++;
      if (overrun !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_clear: overrun=%b valid=%b required 0/0", overrun, out_valid);
      end
      wait_read("bp_rd1");
      vectors++;
      if (mem_address !== 4'd4) begin
         errors++;
         $display("FAIL bp_phase: addr=%0d required 4", mem_address);
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_sample !== rom(1'b1, 4'd4)) begin
         errors++;
         $display("FAIL bp_resume: valid=%b sample=%h required 1/%h", out_valid, out_sample, rom(1'b1, 4'd4));
      end
   endtask

   task automatic test_back_to_back();
      int last;
      logic [3:0] a;
      // div=2: every tick lands in the same cycle as the accept of the previous sample
      do_reset();
      div = 16'd2;
      enable = 1'b1;
      last = 0;
      for (int i = 0; i < 5; i++) begin
         a = 4'(i);
         wait_read("b2b_div2");
         vectors++;
         if (mem_address !== a || (i > 0 && cyc - last != 3)) begin
            errors++;
            $display("FAIL b2b_div2[%0d]: addr=%0d gap=%0d required %0d/3", i, mem_address, cyc - last, a);
         end
         last = cyc;
      end
      vectors++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_div2_overrun: got %b required 0", overrun);
      end
      // div=0: ticks during REQ/CAPT are dropped but still advance the phase
      do_reset();
      div = 16'd0;
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 4'(3 * i);
         wait_read("b2b_div0");
         vectors++;
         if (mem_address !== a || (i > 0 && cyc - last != 3)) begin
            errors++;
            $display("FAIL b2b_div0[%0d]: addr=%0d gap=%0d required %0d/3", i, mem_address, cyc - last, a);
         end
         last = cyc;
      end
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (overrun !== 1'b1 || out_valid !== 1'b1 || out_sample !== rom(1'b1, 4'd6)) begin
         errors++;
         $display("FAIL b2b_div0_out: overrun=%b valid=%b sample=%h required 1/1/%h",
                  overrun, out_valid, out_sample, rom(1'b1, 4'd6));
      end
   endtask

   task automatic test_phase_wrap();
      logic [3:0] exp_a [6];
      exp_a = '{4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
      do_reset();
      freq_word = 16'hFFFF;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_read("wrap");
         if (i == 3) freq_word = 16'h0000;
         vectors++;
         if (mem_address !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, mem_address, exp_a[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_channel_switch();
      test_backpressure();
      test_back_to_back();
      test_phase_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
